hram_responder: RTL and testbench
=================================

HRAM_RESPONDER -- requirements
Module: hram_responder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, one T-cycle per rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port t1, input, 1 bit: high during the first T-cycle (T1) of each CPU M-cycle.
REQ-004 SHALL have port adr, input, 16 bits: CPU bus address, valid at T1.
REQ-005 SHALL have port rd, input, 1 bit: CPU read request, valid at T1.
REQ-006 SHALL have port wr, input, 1 bit: CPU write request, valid at T1.
REQ-007 SHALL have port dout, input, 8 bits: CPU write data, valid at T4.
REQ-008 SHALL have port din, output, 8 bits: read data driven to the CPU.
REQ-009 SHALL have port din_oe, output, 1 bit: high while this block drives din.
REQ-010 SHALL have port reg_ie, output, 5 bits: interrupt-enable register contents.
REQ-011 SHALL have port bus_err, output, 1 bit: one-cycle pulse on a malformed request.

Function
REQ-012 SHALL decode the window 0xFF80-0xFFFE as 127-byte HRAM and 0xFFFF as the IE register; any other address is a miss.
REQ-013 SHALL keep a 2-bit T counter: load T1 when t1=1, otherwise advance T1->T2->T3->T4 and hold at T4 until the next t1.
REQ-014 SHALL latch adr, rd and wr on the edge ending T1; no later change of these inputs SHALL affect the current M-cycle.
REQ-015 SHALL use states IDLE, READ and WRITE: T1 with hit&rd&!wr -> READ; hit&wr&!rd -> WRITE; otherwise -> IDLE.
REQ-016 On a READ, din_oe SHALL be 1 during T2, T3 and T4, and din SHALL show the addressed byte stable over those three cycles.
REQ-017 A read of 0xFFFF SHALL return {3'b111, reg_ie}.
REQ-018 On a WRITE, dout SHALL be committed on the edge ending T4, to HRAM[adr-0xFF80] or to reg_ie (dout[4:0]); din_oe SHALL stay 0.
REQ-019 When din_oe=0, din SHALL be 0xFF.
REQ-020 A miss SHALL leave all storage unchanged and din_oe at 0.
REQ-021 rd=wr=1 at T1 SHALL pulse bus_err for the cycle after T1, perform no access and enter IDLE, whatever the address.
REQ-022 A t1 arriving before T4 completes SHALL abort the current access: no write commit and din_oe low from the next cycle. The new T1 request SHALL then be decoded normally.
REQ-023 Back-to-back M-cycles SHALL be supported: a write committed at the end of T4 SHALL be visible to a read whose T1 follows immediately.

Reset
REQ-024 Asserting reset SHALL immediately force state IDLE, T counter T4, din_oe 0, din 0xFF, bus_err 0 and reg_ie 5'b00000.
REQ-025 HRAM contents SHALL NOT be cleared by reset.
REQ-026 A write pending when reset asserts SHALL be dropped.
REQ-027 After reset releases, no access SHALL begin until the first t1.

Structure
REQ-028 The window bounds (0xFF80, 0xFFFE, 0xFFFF), the T-state enum and the responder state enum SHALL live in the shared CPU bus package.
REQ-029 HRAM storage SHALL be a sub-module hram_127x8: single port, synchronous write, with read data registered at the edge ending T1.

Verification
REQ-030 Write 0x5A to 0xFF80, then read 0xFF80 -> din=0x5A with din_oe=1 over T2-T4 of the read.
REQ-031 Write 0xE3 to 0xFFFF, then read 0xFFFF -> reg_ie=5'b00011 and din=0xE3.
REQ-032 Read 0xC000 -> din_oe=0, din=0xFF, 0xFF80 unchanged.
REQ-033 rd=wr=1 at 0xFF90 -> bus_err pulses once, 0xFF90 keeps its prior value, din_oe=0.
REQ-034 Write 0x77 to 0xFFA0 with t1 re-asserted at T3 -> 0xFFA0 keeps its prior value; the new M-cycle proceeds normally.
REQ-035 Reset asserted at T3 of a write of 0x11 to 0xFFFF -> reg_ie=0 immediately and remains 0 after release.

Source files
------------

// File: rtl/hram_pkg.sv
// Shared CPU bus definitions: the high-page window bounds, the T-cycle
// enumeration and the HRAM responder state enumeration.
package hram_pkg;

  localparam logic [15:0] HRAM_LO = 16'hFF80;
  localparam logic [15:0] HRAM_HI = 16'hFFFE;
  localparam logic [15:0] IE_ADR  = 16'hFFFF;

  typedef enum logic [1:0] {
    T1 = 2'd0,
    T2 = 2'd1,
    T3 = 2'd2,
    T4 = 2'd3
  } tstate_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } rstate_e;

  // T-state that follows t; T4 holds until the next t1 reloads T1.
  function automatic tstate_e t_advance(input tstate_e t);
    tstate_e n;
    case (t)
      T1:      n = T2;
      T2:      n = T3;
      T3:      n = T4;
      default: n = T4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/hram_127x8.sv
// 127 x 8 high RAM: single port, synchronous write, registered read.
// Contents are deliberately not reset.
module hram_127x8 (
  input  logic       clk,
  input  logic       en,
  input  logic       we,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem_r [0:126];

  // One access per cycle: a write wins, otherwise an enabled read is registered.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end else if (en) begin
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/hram_responder.sv
// CPU bus responder for the high page: 127 bytes of HRAM at 0xFF80-0xFFFE
// and the 5-bit interrupt-enable register at 0xFFFF.
// The request is decoded in T1; reads drive din over T2-T4, writes commit
// on the edge ending T4. A new t1 before that edge aborts the access.
module hram_responder
  import hram_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        t1,
  input  logic [15:0] adr,
  input  logic        rd,
  input  logic        wr,
  input  logic [7:0]  dout,
  output logic [7:0]  din,
  output logic        din_oe,
  output logic [4:0]  reg_ie,
  output logic        bus_err
);

  tstate_e    t_r;
  tstate_e    t_cur_s;
  tstate_e    t_next_s;
  rstate_e    state_r;
  rstate_e    state_next_s;

  logic       hram_hit_s;
  logic       ie_hit_s;
  logic       commit_s;
  logic       ie_sel_r;
  logic [6:0] idx_r;
  logic       din_oe_r;
  logic       bus_err_r;
  logic [4:0] ie_r;

  logic       mem_en_s;
  logic       mem_we_s;
  logic [6:0] mem_addr_s;
  logic [7:0] mem_rdata_s;

  assign hram_hit_s = (adr >= HRAM_LO) && (adr <= HRAM_HI);
  assign ie_hit_s   = (adr == IE_ADR);

  // Current T-state, request decode and end-of-T4 write commit.
  always_comb begin
    t_cur_s      = t_r;
    state_next_s = state_r;
    commit_s     = 1'b0;
    if (t1) begin
      t_cur_s = T1;
      if (rd && wr) begin
        state_next_s = IDLE;
      end else if ((hram_hit_s || ie_hit_s) && rd) begin
        state_next_s = READ;
      end else if ((hram_hit_s || ie_hit_s) && wr) begin
        state_next_s = WRITE;
      end else begin
        state_next_s = IDLE;
      end
    end else if (t_r == T4) begin
      commit_s     = (state_r == WRITE);
      state_next_s = IDLE;
    end else begin
      state_next_s = state_r;
    end
    t_next_s = t_advance(t_cur_s);
  end

  // T counter and responder state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_r     <= T4;
      state_r <= IDLE;
    end else begin
      t_r     <= t_next_s;
      state_r <= state_next_s;
    end
  end

  // Request latch, output enables, error pulse and IE register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie_sel_r  <= 1'b0;
      idx_r     <= 7'd0;
      din_oe_r  <= 1'b0;
      bus_err_r <= 1'b0;
      ie_r      <= 5'd0;
    end else begin
      din_oe_r  <= (state_next_s == READ);
      bus_err_r <= t1 & rd & wr;
      if (t1) begin
        ie_sel_r <= ie_hit_s;
        idx_r    <= adr[6:0];
      end
      if (commit_s && ie_sel_r) begin
        ie_r <= dout[4:0];
      end
    end
  end

  // The window starts on a 128-byte boundary, so the HRAM index is adr[6:0].
  assign mem_en_s   = t1 & hram_hit_s & rd & ~wr;
  assign mem_we_s   = commit_s & ~ie_sel_r;
  assign mem_addr_s = t1 ? adr[6:0] : idx_r;

  hram_127x8 u_hram (
    .clk   (clk),
    .en    (mem_en_s),
    .we    (mem_we_s),
    .addr  (mem_addr_s),
    .wdata (dout),
    .rdata (mem_rdata_s)
  );

  assign din     = din_oe_r ? (ie_sel_r ? {3'b111, ie_r} : mem_rdata_s) : 8'hFF;
  assign din_oe  = din_oe_r;
  assign bus_err = bus_err_r;
  assign reg_ie  = ie_r;

endmodule

// File: tb/tb_hram_responder.sv
// Scoreboard bench for hram_responder: each M-cycle pushes its expected
// T2-T4 bus view, which is popped and compared as the cycle plays out.
module tb_hram_responder;

  logic        clk;
  logic        reset;
  logic        t1;
  logic [15:0] adr;
  logic        rd;
  logic        wr;
  logic [7:0]  dout;
  logic [7:0]  din;
  logic        din_oe;
  logic [4:0]  reg_ie;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       oe;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model [0:126];
  logic [4:0] model_ie;

  hram_responder dut (
    .clk     (clk),
    .reset   (reset),
    .t1      (t1),
    .adr     (adr),
    .rd      (rd),
    .wr      (wr),
    .dout    (dout),
    .din     (din),
    .din_oe  (din_oe),
    .reg_ie  (reg_ie),
    .bus_err (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // One M-cycle of len T-cycles (4 = complete, less = aborted by next t1).
  // Called right after an edge (+1); returns right after the last edge.
  task automatic mcyc(input string tag, input logic [15:0] a, input logic r,
                      input logic w, input logic [7:0] d, input int len);
    exp_t e;
    exp_t cur;
    logic hh;
    logic ih;
    logic [6:0] idx;
    idx = a[6:0];
    hh  = (a >= 16'hFF80) && (a <= 16'hFFFE);
    ih  = (a == 16'hFFFF);
    if (r && !w && hh)      e = '{oe: 1'b1, data: model[idx]};
    else if (r && !w && ih) e = '{oe: 1'b1, data: {3'b111, model_ie}};
    else                    e = '{oe: 1'b0, data: 8'hFF};
    exp_q.push_back(e);
    t1 = 1'b1; adr = a; rd = r; wr = w; dout = ~d;
    @(posedge clk); #1;
    t1 = 1'b0; adr = ~a; rd = ~r; wr = ~w;
    for (int k = 2; k <= len; k++) begin
      dout = (k == 4) ? d : ~d;
      cur = exp_q[0];
      total++;
      if (din_oe !== cur.oe) begin
        bad++;
        $display("FAIL %s din_oe T%0d got=%b want=%b", tag, k, din_oe, cur.oe);
      end
      total++;
      if (din !== cur.data) begin
        bad++;
        $display("FAIL %s din T%0d got=%h want=%h", tag, k, din, cur.data);
      end
      total++;
      if (bus_err !== ((k == 2) && r && w)) begin
        bad++;
        $display("FAIL %s bus_err T%0d got=%b want=%b", tag, k, bus_err, (k == 2) && r && w);
      end
      @(posedge clk); #1;
    end
    void'(exp_q.pop_front());
    if (len == 4 && w && !r && hh) model[idx] = d;
    if (len == 4 && w && !r && ih) model_ie = d[4:0];
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    total++;
    if (din_oe !== 1'b0) begin bad++; $display("FAIL reset din_oe got=%b want=0", din_oe); end
    total++;
    if (din !== 8'hFF) begin bad++; $display("FAIL reset din got=%h want=ff", din); end
    total++;
    if (bus_err !== 1'b0) begin bad++; $display("FAIL reset bus_err got=%b want=0", bus_err); end
    total++;
    if (reg_ie !== 5'd0) begin bad++; $display("FAIL reset reg_ie got=%b want=00000", reg_ie); end
    reset = 1'b0;
    // No access may start without a t1, even with a request on the bus.
    adr = 16'hFFFF; rd = 1'b1; wr = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (din_oe !== 1'b0) begin bad++; $display("FAIL post_reset din_oe got=%b want=0", din_oe); end
    end
    rd = 1'b0;
  endtask

  task automatic test_rw_basic;
    mcyc("wr_ff80", 16'hFF80, 1'b0, 1'b1, 8'h5A, 4);
    mcyc("rd_ff80", 16'hFF80, 1'b1, 1'b0, 8'h00, 4);
  endtask

  task automatic test_ie;
    mcyc("wr_ie", 16'hFFFF, 1'b0, 1'b1, 8'hE3, 4);
    total++;
    if (reg_ie !== 5'b00011) begin bad++; $display("FAIL ie_reg got=%b want=00011", reg_ie); end
    mcyc("rd_ie", 16'hFFFF, 1'b1, 1'b0, 8'h00, 4);
  endtask

  task automatic test_miss;
    mcyc("rd_c000", 16'hC000, 1'b1, 1'b0, 8'h00, 4);
    mcyc("wr_7f80", 16'h7F80, 1'b0, 1'b1, 8'hC3, 4);
    mcyc("wr_ff7f", 16'hFF7F, 1'b0, 1'b1, 8'h3C, 4);
    mcyc("rd_ff80_after_miss", 16'hFF80, 1'b1, 1'b0, 8'h00, 4);
  endtask

  task automatic test_bus_err;
    mcyc("wr_ff90", 16'hFF90, 1'b0, 1'b1, 8'h42, 4);
    mcyc("rdwr_ff90", 16'hFF90, 1'b1, 1'b1, 8'h99, 4);
    mcyc("rd_ff90", 16'hFF90, 1'b1, 1'b0, 8'h00, 4);
    mcyc("rdwr_c000", 16'hC000, 1'b1, 1'b1, 8'h99, 4);
  endtask

  task automatic test_abort;
    mcyc("wr_ffa0", 16'hFFA0, 1'b0, 1'b1, 8'h21, 4);
    mcyc("wr_ffa0_abort", 16'hFFA0, 1'b0, 1'b1, 8'h77, 3);
    mcyc("rd_ffa0", 16'hFFA0, 1'b1, 1'b0, 8'h00, 4);
    mcyc("rd_ffa0_abort", 16'hFFA0, 1'b1, 1'b0, 8'h00, 2);
    mcyc("rd_ff80_after_abort", 16'hFF80, 1'b1, 1'b0, 8'h00, 4);
  endtask

  task automatic test_back_to_back;
    logic [15:0] a;
    logic [7:0]  d;
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? 16'hFFFE : 16'hFFB0 + 16'($urandom_range(0, 63));
      d = 8'($urandom_range(0, 255));
      mcyc("b2b_wr", a, 1'b0, 1'b1, d, 4);
      mcyc("b2b_rd", a, 1'b1, 1'b0, 8'h00, 4);
    end
  endtask

  task automatic test_reset_write;
    t1 = 1'b1; adr = 16'hFFFF; rd = 1'b0; wr = 1'b1; dout = 8'h00;
    @(posedge clk); #1;
    t1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    dout  = 8'h11;
    #1;
    total++;
    if (reg_ie !== 5'd0) begin bad++; $display("FAIL rst_wr reg_ie_now got=%b want=00000", reg_ie); end
    total++;
    if (din !== 8'hFF) begin bad++; $display("FAIL rst_wr din got=%h want=ff", din); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_ie = 5'd0;
    repeat (4) begin
      @(posedge clk); #1;
      total++;
      if (reg_ie !== 5'd0) begin bad++; $display("FAIL rst_wr reg_ie_after got=%b want=00000", reg_ie); end
    end
    // HRAM survives reset.
    mcyc("rd_ff80_after_reset", 16'hFF80, 1'b1, 1'b0, 8'h00, 4);
    mcyc("rd_ie_after_reset", 16'hFFFF, 1'b1, 1'b0, 8'h00, 4);
  endtask

  initial begin
    reset = 1'b1; t1 = 1'b0; adr = 16'h0000; rd = 1'b0; wr = 1'b0; dout = 8'h00;
    model_ie = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_rw_basic;
    test_ie;
    test_miss;
    test_bus_err;
    test_abort;
    test_back_to_back;
    test_reset_write;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
